// File: rtl/fetch_bpred_if.sv
// Fetch/BTB bus: execute-side control and feedback in, fetch address and prediction out.
interface fetch_bpred_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  stall;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    // Execute stage / environment side
    modport master (
        output stall, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, pc_plus4, pred_taken, pred_target
    );

    // Fetch stage side
    modport slave (
        input  stall, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output pc, pc_plus4, pred_taken, pred_target
    );
endinterface

// File: rtl/fetch_bpred.sv
// Fetch stage: PC register plus a direct-mapped BTB with 2-bit saturating
// counters, predicting taken branches/jumps at fetch.
module fetch_bpred #(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          BTB_ENTRIES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_bpred_if.slave  bus
);
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX - 2;

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] redirect_aligned;

    // Word addresses (byte offset dropped) for lookup and update
    logic [DATA_WIDTH-3:0] pc_word;
    logic [DATA_WIDTH-3:0] upd_word;
    logic [IDX-1:0]        rd_idx;
    logic [IDX-1:0]        wr_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [TAG_W-1:0]      wr_tag;

    logic                  btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]            btb_ctr    [BTB_ENTRIES];

    logic                  rd_hit;
    logic                  upd_hit;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    assign pc_plus4         = pc_q + DATA_WIDTH'(4);
    assign redirect_aligned = bus.redirect_pc & ~DATA_WIDTH'(3);

    assign pc_word  = pc_q[DATA_WIDTH-1:2];
    assign upd_word = (DATA_WIDTH-2)'(bus.upd_pc >> 2);
    assign rd_idx   = pc_word[IDX-1:0];
    assign rd_tag   = pc_word[DATA_WIDTH-3:IDX];
    assign wr_idx   = upd_word[IDX-1:0];
    assign wr_tag   = upd_word[DATA_WIDTH-3:IDX];

    // Lookup reads the pre-update array, so a same-cycle write is seen next cycle
    assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && btb_ctr[rd_idx][1];
    assign pred_target = rd_hit ? btb_target[rd_idx] : pc_plus4;
    assign upd_hit     = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

    // Next-PC selection: reset, redirect, stall, prediction, sequential
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect) begin
            pc_q <= redirect_aligned;
        end else if (bus.stall) begin
            pc_q <= pc_q;
        end else if (pred_taken) begin
            pc_q <= pred_target;
        end else begin
            pc_q <= pc_plus4;
        end
    end

    // Valid bits: cleared on reset, set when a taken miss allocates an entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (bus.upd_valid && bus.upd_taken && !upd_hit) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    // Entry payload: train counter/target on hit, allocate weakly-taken on taken miss
    always_ff @(posedge clk) begin
        if (!rst && bus.upd_valid) begin
            if (upd_hit) begin
                if (bus.upd_taken) begin
                    btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'b11) ? 2'b11 : btb_ctr[wr_idx] + 2'b01;
                    btb_target[wr_idx] <= bus.upd_target;
                end else begin
                    btb_ctr[wr_idx]    <= (btb_ctr[wr_idx] == 2'b00) ? 2'b00 : btb_ctr[wr_idx] - 2'b01;
                end
            end else if (bus.upd_taken) begin
                btb_tag[wr_idx]    <= wr_tag;
                btb_target[wr_idx] <= bus.upd_target;
                btb_ctr[wr_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_fetch_bpred.sv
// Directed, table-driven bench for fetch_bpred (BTB_ENTRIES=16, RESET_PC=0).
module tb_fetch_bpred;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_bpred_if #(.DATA_WIDTH(32)) bus ();

    fetch_bpred #(
        .DATA_WIDTH (32),
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic [31:0] upd_target;
        logic        upd_taken;
        logic [31:0] exp_pc;
        logic        exp_pt;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc,
                                logic uv, logic [31:0] upc, logic [31:0] utgt, logic utk,
                                logic [31:0] epc, logic ept, logic [31:0] etgt);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.redirect_pc = rpc;
        v.upd_valid = uv; v.upd_pc = upc; v.upd_target = utgt; v.upd_taken = utk;
        v.exp_pc = epc; v.exp_pt = ept; v.exp_tgt = etgt;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, id, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.stall       = v.stall;
        bus.redirect    = v.redirect;
        bus.redirect_pc = v.redirect_pc;
        bus.upd_valid   = v.upd_valid;
        bus.upd_pc      = v.upd_pc;
        bus.upd_target  = v.upd_target;
        bus.upd_taken   = v.upd_taken;
    endtask

    initial begin
        //              rst s  rd rpc           uv upc      utgt     tk  exp_pc       pt exp_tgt
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h0,        0, 32'h4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h0,        0, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h4,        0, 32'h8));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h8,        0, 32'hC));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'hC,        0, 32'h10));
        // allocate 0x10 -> 0x40 (ctr=2) while pc steps onto 0x10
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h10,       1, 32'h40));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h40,       0, 32'h44));
        // three taken updates: ctr saturates at 3
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h44,       0, 32'h48));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h48,       0, 32'h4C));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h4C,       0, 32'h50));
        // not-taken: 3->2 (still taken), 2->1 (not taken)
        vecs.push_back(mk(0, 0, 1, 32'h10,       1, 32'h10, 32'h0,   0, 32'h10,       1, 32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10, 32'h0,   0, 32'h10,       0, 32'h40));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h14,       0, 32'h18));
        // two more not-taken: 1->0, stays 0
        vecs.push_back(mk(0, 0, 1, 32'h10,       1, 32'h10, 32'h0,   0, 32'h10,       0, 32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10, 32'h0,   0, 32'h10,       0, 32'h40));
        // from 0 two taken updates needed to predict taken again
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h10,       0, 32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10, 32'h40,  1, 32'h10,       1, 32'h40));
        // aliasing on index 4
        vecs.push_back(mk(0, 0, 1, 32'h50,       0, 32'h0,  32'h0,   0, 32'h50,       0, 32'h54));
        vecs.push_back(mk(0, 0, 1, 32'h50,       1, 32'h50, 32'h80,  1, 32'h50,       1, 32'h80));
        vecs.push_back(mk(0, 0, 1, 32'h10,       0, 32'h0,  32'h0,   0, 32'h10,       0, 32'h14));
        // priority
        vecs.push_back(mk(0, 0, 1, 32'h50,       0, 32'h0,  32'h0,   0, 32'h50,       1, 32'h80));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h50,       1, 32'h80));
        vecs.push_back(mk(0, 1, 1, 32'h203,      0, 32'h0,  32'h0,   0, 32'h200,      0, 32'h204));
        vecs.push_back(mk(0, 0, 1, 32'h50,       0, 32'h0,  32'h0,   0, 32'h50,       1, 32'h80));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h80,       0, 32'h84));
        // reset beats redirect and update; BTB is cleared
        vecs.push_back(mk(1, 0, 1, 32'h50,       1, 32'h80, 32'h100, 1, 32'h0,        0, 32'h4));
        vecs.push_back(mk(0, 0, 1, 32'h50,       0, 32'h0,  32'h0,   0, 32'h50,       0, 32'h54));
        vecs.push_back(mk(0, 0, 1, 32'h80,       0, 32'h0,  32'h0,   0, 32'h80,       0, 32'h84));
        // wrap
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,  32'h0,   0, 32'hFFFFFFFC, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h0,        0, 32'h4));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check("pc",          i, bus.pc,                  vecs[i].exp_pc);
            check("pc_plus4",    i, bus.pc_plus4,            vecs[i].exp_pc + 32'd4);
            check("pred_taken",  i, {31'b0, bus.pred_taken}, {31'b0, vecs[i].exp_pt});
            check("pred_target", i, bus.pred_target,         vecs[i].exp_tgt);
        end

        // Same-cycle update and lookup on index 8: old view now, new view after the edge
        drive(mk(0, 0, 1, 32'h20, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0));
        @(posedge clk);
        #1;
        check("hz_pc", 100, bus.pc, 32'h20);
        drive(mk(0, 1, 0, 32'h0, 1, 32'h20, 32'h60, 1, 32'h0, 0, 32'h0));
        #1;
        check("hz_pt_old", 101, {31'b0, bus.pred_taken}, 32'd0);
        check("hz_tgt_old", 101, bus.pred_target, 32'h24);
        @(posedge clk);
        #1;
        check("hz_pc_stall", 102, bus.pc, 32'h20);
        check("hz_pt_new", 102, {31'b0, bus.pred_taken}, 32'd1);
        check("hz_tgt_new", 102, bus.pred_target, 32'h60);
        drive(mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0));
        @(posedge clk);
        #1;
        check("hz_pc_follow", 103, bus.pc, 32'h60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
